// File: rtl/data_ram_pkg.sv
// Shared definitions for the wait-state data RAM responder:
// FSM state encoding and the legal byte-select patterns.
package data_ram_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [SEL_W-1:0] SEL_READ    = 4'b0000;
   localparam logic [SEL_W-1:0] SEL_WORD    = 4'b1111;
   localparam logic [SEL_W-1:0] SEL_HALF_LO = 4'b0011;
   localparam logic [SEL_W-1:0] SEL_HALF_HI = 4'b1100;
   localparam logic [SEL_W-1:0] SEL_BYTE0   = 4'b0001;
   localparam logic [SEL_W-1:0] SEL_BYTE1   = 4'b0010;
   localparam logic [SEL_W-1:0] SEL_BYTE2   = 4'b0100;
   localparam logic [SEL_W-1:0] SEL_BYTE3   = 4'b1000;

   // True for aligned word, halfword and byte patterns (and read).
   function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
      logic legal;
      legal = 1'b0;
      case (sel)
         SEL_READ, SEL_WORD, SEL_HALF_LO, SEL_HALF_HI,
         SEL_BYTE0, SEL_BYTE1, SEL_BYTE2, SEL_BYTE3: legal = 1'b1;
         default: legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/bytewrite_ram.sv
// Single-clock RAM with per-byte write enables and a registered read port.
module bytewrite_ram
   import data_ram_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [SEL_W-1:0]  i_be,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Lane-masked write and registered full-word read; contents never reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < SEL_W; b++) begin
         if (i_we && i_be[b]) begin
            r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
      if (i_re) begin
         o_rdata <= r_mem[i_raddr];
      end
   end

endmodule

// File: rtl/data_ram_resp.sv
// Data RAM responder: accepts one request at a time, inserts WAIT_CYCLES
// wait states, performs the access once and pulses data_ok for one cycle.
// Optional feature macro: DATA_RAM_SEL_CHECK_EN -- illegal select patterns
// suppress the write and raise err alongside data_ok.
module data_ram_resp
   import data_ram_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req,
   input  logic [SEL_W-1:0]  select,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              addr_ok,
   output logic              data_ok,
   output logic [DATA_W-1:0] rdata,
   output logic              err
);

   localparam logic             NO_WAIT  = (WAIT_CYCLES == 0);
   localparam logic [CNT_W-1:0] CNT_INIT = NO_WAIT ? '0 : CNT_W'(WAIT_CYCLES - 1);

   state_e              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [SEL_W-1:0]    r_sel;
   logic [ADDR_W-1:0]   r_idx;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_data_ok;
   logic                r_rd;
   logic                r_err;

   logic                w_accept;
   logic                w_fire;
   logic [SEL_W-1:0]    w_sel;
   logic [ADDR_W-1:0]   w_idx;
   logic [DATA_W-1:0]   w_wdata;
   logic                w_is_wr;
   logic                w_we;
   logic                w_re;
   logic                w_err_set;
   logic [DATA_W-1:0]   w_ram_q;
   logic                w_unused_addr;

   assign w_unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

   assign w_accept = (r_state == IDLE) && req;
   assign addr_ok  = w_accept;

   // The access fires on the edge that enters RESP; with no wait states
   // that is the accept edge itself, so the live request is used.
   assign w_fire  = resetn && ((w_accept && NO_WAIT) ||
                               ((r_state == WAIT) && (r_cnt == '0)));
   assign w_sel   = (r_state == IDLE) ? select : r_sel;
   assign w_idx   = (r_state == IDLE) ? addr[ADDR_W+1:2] : r_idx;
   assign w_wdata = (r_state == IDLE) ? wdata : r_wdata;
   assign w_is_wr = |w_sel;
   assign w_re    = w_fire && !w_is_wr;

`ifdef DATA_RAM_SEL_CHECK_EN
   assign w_we      = w_fire && w_is_wr && sel_legal(w_sel);
   assign w_err_set = w_fire && !sel_legal(w_sel);
`else
   assign w_we      = w_fire && w_is_wr;
   assign w_err_set = 1'b0;
`endif

   bytewrite_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_be    (w_sel),
      .i_waddr (w_idx),
      .i_wdata (w_wdata),
      .i_re    (w_re),
      .i_raddr (w_idx),
      .o_rdata (w_ram_q)
   );

   // Transaction FSM with request capture, wait counter and response flags.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_sel     <= '0;
         r_idx     <= '0;
         r_wdata   <= '0;
         r_data_ok <= 1'b0;
         r_rd      <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_data_ok <= 1'b0;
         r_err     <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req) begin
                  r_sel   <= select;
                  r_idx   <= addr[ADDR_W+1:2];
                  r_wdata <= wdata;
                  if (NO_WAIT) begin
                     r_state <= RESP;
                  end else begin
                     r_state <= WAIT;
                     r_cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= RESP;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            RESP: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
         if (w_fire) begin
            r_data_ok <= 1'b1;
            r_rd      <= !w_is_wr;
            r_err     <= w_err_set;
         end
      end
   end

   assign data_ok = r_data_ok;
   assign err     = r_err;
   assign rdata   = (r_data_ok && r_rd) ? w_ram_q : '0;

endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench for data_ram_resp: directed scenarios plus randomized
// traffic compared against a word-array reference model.
module tb_data_ram_resp;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned WAITC  = 2;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   logic        clk;
   logic        resetn;
   logic        req;
   logic [3:0]  select;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic        err;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] m_mem [DEPTH];
   logic [3:0]  legal_tab [8] = '{4'b0000, 4'b1111, 4'b0011, 4'b1100,
                                  4'b0001, 4'b0010, 4'b0100, 4'b1000};

   data_ram_resp #(
      .ADDR_W      (ADDR_W),
      .WAIT_CYCLES (WAITC)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .req     (req),
      .select  (select),
      .addr    (addr),
      .wdata   (wdata),
      .addr_ok (addr_ok),
      .data_ok (data_ok),
      .rdata   (rdata),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit m_legal(input logic [3:0] s);
      for (int i = 0; i < 8; i++) if (legal_tab[i] == s) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_index(input logic [31:0] a);
      return int'((a / 4) % DEPTH);
   endfunction

   // Reference behaviour: apply one transaction, return the expected err.
   function automatic bit m_apply(input logic [3:0] s, input logic [31:0] a,
                                  input logic [31:0] d);
      int  idx;
      bit  e;
      idx = m_index(a);
      e   = 1'b0;
`ifdef DATA_RAM_SEL_CHECK_EN
      e = !m_legal(s);
`endif
      if (!e) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) m_mem[idx][8*b +: 8] = d[8*b +: 8];
      end
      return e;
   endfunction

   // Drive one request, return response values and accept-to-data_ok latency.
   task automatic txn(input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd,
                      output logic er, output int lat, output bit pulse_ok);
      bit seen;
      @(negedge clk);
      req = 1'b1; select = s; addr = a; wdata = d;
      #1;
      n_cmp++;
      if (addr_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL txn_accept: addr_ok=%b required 1 (addr=%h)", addr_ok, a);
      end
      @(posedge clk);
      #1 req = 1'b0; select = 4'b0000;
      rd = '0; er = 1'b0; lat = 0; seen = 1'b0; pulse_ok = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (data_ok === 1'b1) begin
            seen = 1'b1; rd = rdata; er = err;
         end
      end
      if (!seen) begin
         n_cmp++; n_fail++;
         $display("FAIL txn_timeout: no data_ok within %0d cycles (addr=%h)", lat, a);
      end
      @(negedge clk);
      pulse_ok = (data_ok === 1'b0);
   endtask

   task automatic test_reset();
      resetn = 1'b0; req = 1'b0; select = '0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (data_ok !== 1'b0) begin n_fail++; $display("FAIL reset_data_ok: got %b required 0", data_ok); end
      n_cmp++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
      n_cmp++;
      if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", rdata); end
      n_cmp++;
      if (addr_ok !== 1'b0) begin n_fail++; $display("FAIL reset_addr_ok: got %b required 0", addr_ok); end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [31:0] rd; logic er; int lat; bit p; bit ee;
      // full-word write
      ee = m_apply(4'b1111, 32'h10, 32'hDEADBEEF);
      txn(4'b1111, 32'h10, 32'hDEADBEEF, rd, er, lat, p);
      n_cmp++;
      if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d required 3", lat); end
      n_cmp++;
      if (er !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b required 0", er); end
      n_cmp++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL wr_rdata_zero: got %h required 0", rd); end
      n_cmp++;
      if (!p) begin n_fail++; $display("FAIL wr_pulse: data_ok got 1 required 0 after one cycle"); end
      // read back
      txn(4'b0000, 32'h10, 32'h0, rd, er, lat, p);
      n_cmp++;
      if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d required 3", lat); end
      n_cmp++;
      if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_word: got %h required DEADBEEF", rd); end
      // single byte lane 2
      ee = m_apply(4'b0100, 32'h12, 32'h55555555);
      txn(4'b0100, 32'h12, 32'h55555555, rd, er, lat, p);
      txn(4'b0000, 32'h10, 32'h0, rd, er, lat, p);
      n_cmp++;
      if (rd !== 32'hDE55BEEF) begin n_fail++; $display("FAIL byte_write: got %h required DE55BEEF", rd); end
      // illegal pattern
      ee = m_apply(4'b0110, 32'h10, 32'h0);
      txn(4'b0110, 32'h10, 32'h0, rd, er, lat, p);
`ifdef DATA_RAM_SEL_CHECK_EN
      n_cmp++;
      if (er !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b required 1", er); end
      txn(4'b0000, 32'h10, 32'h0, rd, er, lat, p);
      n_cmp++;
      if (rd !== 32'hDE55BEEF) begin n_fail++; $display("FAIL illegal_rd: got %h required DE55BEEF", rd); end
`else
      n_cmp++;
      if (er !== 1'b0) begin n_fail++; $display("FAIL illegal_err: got %b required 0", er); end
      txn(4'b0000, 32'h10, 32'h0, rd, er, lat, p);
      n_cmp++;
      if (rd !== 32'hDE0000EF) begin n_fail++; $display("FAIL illegal_rd: got %h required DE0000EF", rd); end
`endif
   endtask

   task automatic test_hold_req();
      logic [31:0] rd; logic er; int lat; bit p; bit ee;
      logic [31:0] v1, v2;
      bit seen, stray;
      int c;
      v1 = $urandom; v2 = $urandom;
      ee = m_apply(4'b1111, 32'h80, v2);
      txn(4'b1111, 32'h80, v2, rd, er, lat, p);
      @(negedge clk);
      req = 1'b1; select = 4'b1111; addr = 32'h40; wdata = v1;
      #1;
      n_cmp++;
      if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL hold_first_accept: got %b required 1", addr_ok); end
      ee = m_apply(4'b1111, 32'h40, v1);
      @(posedge clk);
      #1 addr = 32'h80; select = 4'b0000;
      seen = 1'b0; stray = 1'b0; c = 0;
      while (!seen && c < 20) begin
         @(negedge clk);
         c++;
         if (addr_ok !== 1'b0) stray = 1'b1;
         if (data_ok === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (stray || !seen) begin
         n_fail++;
         $display("FAIL hold_busy: stray_addr_ok=%b data_ok_seen=%b required 0/1", stray, seen);
      end
      @(negedge clk);
      n_cmp++;
      if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL hold_dead_cycle_accept: got %b required 1", addr_ok); end
      @(posedge clk);
      #1 req = 1'b0;
      seen = 1'b0; c = 0; rd = '0;
      while (!seen && c < 20) begin
         @(negedge clk);
         c++;
         if (data_ok === 1'b1) begin seen = 1'b1; rd = rdata; end
      end
      n_cmp++;
      if (!seen || rd !== m_mem[m_index(32'h80)]) begin
         n_fail++;
         $display("FAIL hold_second_read: got %h required %h", rd, m_mem[m_index(32'h80)]);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int lat; bit p; bit ee;
      logic [31:0] v;
      bit stray;
      v = $urandom;
      ee = m_apply(4'b1111, 32'h20, v);
      txn(4'b1111, 32'h20, v, rd, er, lat, p);
      @(negedge clk);
      req = 1'b1; select = 4'b1111; addr = 32'h20; wdata = 32'h12345678;
      @(posedge clk);
      #1 req = 1'b0; select = 4'b0000;
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      stray = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (data_ok !== 1'b0) stray = 1'b1;
      end
      n_cmp++;
      if (stray) begin n_fail++; $display("FAIL reset_mid_data_ok: got 1 required 0"); end
      txn(4'b0000, 32'h20, 32'h0, rd, er, lat, p);
      n_cmp++;
      if (rd !== v) begin n_fail++; $display("FAIL reset_mid_contents: got %h required %h", rd, v); end
   endtask

   task automatic test_random();
      logic [31:0] rd; logic er; int lat; bit p; bit ee;
      logic [3:0]  s;
      logic [31:0] a, d, exp_rd;
      for (int w = 0; w < 16; w++) begin
         d = $urandom;
         a = 32'(w * 4);
         ee = m_apply(4'b1111, a, d);
         txn(4'b1111, a, d, rd, er, lat, p);
      end
      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 3) == 0) s = 4'($urandom_range(0, 15));
         else s = legal_tab[$urandom_range(0, 7)];
         a = ($urandom & 32'hFFFF_F003) | 32'($urandom_range(0, 15) * 4);
         d = $urandom;
         exp_rd = (s == 4'b0000) ? m_mem[m_index(a)] : 32'h0;
         ee = m_apply(s, a, d);
         txn(s, a, d, rd, er, lat, p);
         n_cmp++;
         if (rd !== exp_rd || er !== ee || lat != int'(WAITC) + 1 || !p) begin
            n_fail++;
            $display("FAIL rand_%0d: sel=%b addr=%h rdata=%h err=%b lat=%0d pulse=%b required rdata=%h err=%b lat=%0d pulse=1",
                     t, s, a, rd, er, lat, p, exp_rd, ee, WAITC + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold_req();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/data_ram_resp.md
DATA_RAM_RESP -- requirements
Module: data_ram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address bits (memory depth 2^ADDR_W words of 32 bits).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted between accept and access (range 0..15).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port req  in  1  initiator request valid.
REQ-006 SHALL have port select  in  4  byte enables; 4'b0000 means read, nonzero means write.
REQ-007 SHALL have port addr  in  32  byte address; bits [ADDR_W+1:2] index the word, other bits ignored.
REQ-008 SHALL have port wdata  in  32  write data, already lane-replicated by the initiator.
REQ-009 SHALL have port addr_ok  out  1  request accepted this cycle.
REQ-010 SHALL have port data_ok  out  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  out  32  read word, valid while data_ok=1.
REQ-012 SHALL have port err  out  1  illegal select pattern, valid while data_ok=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 SHALL drive addr_ok=1 combinationally only when state=IDLE and req=1.
REQ-015 On accept, SHALL latch select, addr word index and wdata; go to WAIT with counter=WAIT_CYCLES-1, or straight to RESP if WAIT_CYCLES=0.
REQ-016 In WAIT, SHALL decrement counter each cycle and enter RESP the cycle after counter=0.
REQ-017 On entry to RESP, SHALL perform the access once: write only the byte lanes whose select bit is 1; for reads, register the full word into rdata.
REQ-018 SHALL assert data_ok for exactly the one RESP cycle, then return to IDLE; latency accept-edge to data_ok = WAIT_CYCLES+1 cycles.
REQ-019 SHALL ignore req while not IDLE; the initiator holds req until addr_ok.
REQ-020 SHALL allow a new accept in the IDLE cycle right after RESP (one dead cycle between transactions).
REQ-021 For writes, SHALL drive rdata=32'h0 during data_ok.
REQ-022 SHALL return newly written data on a read that follows a write to the same word.
REQ-023 Legal select patterns: 0000, 1111, 0011, 1100, 0001, 0010, 0100, 1000.

Reset
REQ-024 When resetn=0 at a clock edge, SHALL force state=IDLE, counter=0, data_ok=0, err=0, rdata=0, including mid-transaction (the pending access is dropped, no write occurs).
REQ-025 SHALL NOT initialise memory contents on reset.

Configuration
REQ-026 Macro DATA_RAM_SEL_CHECK_EN: when defined, an illegal select SHALL suppress the write and assert err with data_ok; when undefined, err SHALL be tied 0 and every nonzero select SHALL write its enabled lanes.

Structure
REQ-027 Shared package data_ram_pkg SHALL hold the FSM state enum and the legal select constants.
REQ-028 Byte-lane RAM array SHALL be a sub-module bytewrite_ram (one write port with 4-bit lane enables, one read port, synchronous).

Verification
REQ-029 WAIT_CYCLES=2: write select=1111 addr=0x10 wdata=0xDEADBEEF -> addr_ok cycle N, data_ok cycle N+3, err=0.
REQ-030 Then read select=0000 addr=0x10 -> data_ok after 3 cycles, rdata=0xDEADBEEF.
REQ-031 Write select=0100 addr=0x12 wdata=0x55555555 over 0xDEADBEEF, read back -> rdata=0xDE55BEEF.
REQ-032 With macro defined, select=0110 wdata=0 to addr=0x10 -> data_ok with err=1; read back unchanged 0xDE55BEEF; macro undefined -> err=0, read gives 0xDE0000EF.
REQ-033 req held high during WAIT with different addr -> addr_ok stays 0 until the IDLE cycle after data_ok; second request then accepted.
REQ-034 resetn=0 during WAIT of write 0x12345678 to addr=0x20 -> no data_ok, state IDLE; subsequent read addr=0x20 returns the prior contents.
